// File: rtl/charge_discharge_fsm.sv
// -----------------------------------------------------------------------------
// charge_discharge_fsm
//   Battery charge/discharge path controller. Debounces the charger-detect and
//   load-request inputs, applies SOC hysteresis to produce full/empty inhibit
//   flags, and sequences the charge and discharge enables through a dead-time
//   state so the two paths are never enabled together. Any fault forces an
//   immediate shutdown into FAULT, which is left only on an explicit clear.
//
// Ports
//   clk              : single clock
//   rst_n            : asynchronous active-low reset
//   charger_present  : raw charger-detect request
//   load_request     : raw load/drive request
//   soc_percent[7:0] : state of charge, 0-100 (larger values clamp to 100)
//   fault_in         : aggregated OV/UV/OT fault, level
//   fault_clear      : single-cycle fault acknowledge
//   charge_en_fsm    : charge path enable (registered)
//   discharge_en_fsm : discharge path enable (registered)
//   state_code[2:0]  : IDLE=0 CHARGE=1 DISCHARGE=2 DEADTIME=3 FAULT=4
//   fault_latched    : high while in FAULT
//   chg_full         : charge inhibit flag (hysteresis on SOC)
//   dis_empty        : discharge inhibit flag (hysteresis on SOC)
// -----------------------------------------------------------------------------
module charge_discharge_fsm #(
  parameter logic [7:0]  SOC_CHG_STOP   = 8'd100,
  parameter logic [7:0]  SOC_CHG_RESUME = 8'd95,
  parameter logic [7:0]  SOC_DIS_CUTOFF = 8'd5,
  parameter logic [7:0]  SOC_DIS_RESUME = 8'd10,
  parameter int unsigned DEBOUNCE_CYC   = 4,
  parameter int unsigned DEADTIME_CYC   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       charger_present,
  input  logic       load_request,
  input  logic [7:0] soc_percent,
  input  logic       fault_in,
  input  logic       fault_clear,
  output logic       charge_en_fsm,
  output logic       discharge_en_fsm,
  output logic [2:0] state_code,
  output logic       fault_latched,
  output logic       chg_full,
  output logic       dis_empty
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_DISCHARGE = 3'd2,
    ST_DEADTIME  = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int unsigned   DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned   DT_W    = $clog2(DEADTIME_CYC + 1);
  // Debounce flips on the DEBOUNCE_CYC-th differing sample, so the compare
  // value is one less than the required sample count.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  // Counter runs DEADTIME_CYC-1 .. 0, giving DEADTIME_CYC cycles in the state.
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME_CYC - 1);
  localparam logic [7:0]      SOC_MAX = 8'd100;

  state_t          r_state;
  logic            r_chg_en;
  logic            r_dis_en;
  logic            r_fault;
  logic            r_chg_full;
  logic            r_dis_empty;
  logic            r_cp_db;
  logic            r_lr_db;
  logic [DB_W-1:0] r_cp_cnt;
  logic [DB_W-1:0] r_lr_cnt;
  logic [DT_W-1:0] r_dt_cnt;

  logic [7:0]      w_soc;
  logic            w_chg_full_nxt;
  logic            w_dis_empty_nxt;
  state_t          w_state_nxt;

  assign w_soc = (soc_percent > SOC_MAX) ? SOC_MAX : soc_percent;

  // Hysteresis flags; the FSM looks at the next-edge value so that a
  // threshold crossing and the resulting state change land on the same edge.
  always_comb begin
    w_chg_full_nxt = r_chg_full;
    if (w_soc >= SOC_CHG_STOP)
      w_chg_full_nxt = 1'b1;
    else if (w_soc <= SOC_CHG_RESUME)
      w_chg_full_nxt = 1'b0;

    w_dis_empty_nxt = r_dis_empty;
    if (w_soc <= SOC_DIS_CUTOFF)
      w_dis_empty_nxt = 1'b1;
    else if (w_soc >= SOC_DIS_RESUME)
      w_dis_empty_nxt = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (fault_in) begin
      w_state_nxt = ST_FAULT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_cp_db && !w_chg_full_nxt)
            w_state_nxt = ST_CHARGE;
          else if (r_lr_db && !w_dis_empty_nxt)
            w_state_nxt = ST_DISCHARGE;
        end
        ST_CHARGE: begin
          if (!r_cp_db || w_chg_full_nxt)
            w_state_nxt = ST_DEADTIME;
        end
        ST_DISCHARGE: begin
          if (!r_lr_db || w_dis_empty_nxt)
            w_state_nxt = ST_DEADTIME;
        end
        ST_DEADTIME: begin
          if (r_dt_cnt == '0)
            w_state_nxt = ST_IDLE;
        end
        ST_FAULT: begin
          // fault_in is known low here; a clear seen while the fault is
          // still present is simply dropped.
          if (fault_clear)
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_chg_en    <= 1'b0;
      r_dis_en    <= 1'b0;
      r_fault     <= 1'b0;
      r_chg_full  <= 1'b0;
      r_dis_empty <= 1'b0;
      r_cp_db     <= 1'b0;
      r_lr_db     <= 1'b0;
      r_cp_cnt    <= '0;
      r_lr_cnt    <= '0;
      r_dt_cnt    <= '0;
    end else begin
      // Debounce: count consecutive samples that disagree with the filtered
      // value; any agreeing sample restarts the count.
      if (charger_present != r_cp_db) begin
        if (r_cp_cnt == DB_LAST) begin
          r_cp_db  <= charger_present;
          r_cp_cnt <= '0;
        end else begin
          r_cp_cnt <= r_cp_cnt + DB_W'(1);
        end
      end else begin
        r_cp_cnt <= '0;
      end

      if (load_request != r_lr_db) begin
        if (r_lr_cnt == DB_LAST) begin
          r_lr_db  <= load_request;
          r_lr_cnt <= '0;
        end else begin
          r_lr_cnt <= r_lr_cnt + DB_W'(1);
        end
      end else begin
        r_lr_cnt <= '0;
      end

      r_chg_full  <= w_chg_full_nxt;
      r_dis_empty <= w_dis_empty_nxt;

      r_state  <= w_state_nxt;
      r_chg_en <= (w_state_nxt == ST_CHARGE);
      r_dis_en <= (w_state_nxt == ST_DISCHARGE);
      r_fault  <= (w_state_nxt == ST_FAULT);

      if ((w_state_nxt == ST_DEADTIME) && (r_state != ST_DEADTIME))
        r_dt_cnt <= DT_LOAD;
      else if (r_dt_cnt != '0)
        r_dt_cnt <= r_dt_cnt - DT_W'(1);
    end
  end

  assign charge_en_fsm    = r_chg_en;
  assign discharge_en_fsm = r_dis_en;
  assign state_code       = r_state;
  assign fault_latched    = r_fault;
  assign chg_full         = r_chg_full;
  assign dis_empty        = r_dis_empty;

endmodule

// File: doc/charge_discharge_fsm.md
CHARGE_DISCHARGE_FSM -- requirements
Module: charge_discharge_fsm

Interface
REQ-001 Parameters SHALL be:
- SOC_CHG_STOP, default 8'd100, charge termination threshold in %.
- SOC_CHG_RESUME, default 8'd95, charge re-enable threshold in %.
- SOC_DIS_CUTOFF, default 8'd5, discharge cutoff threshold in %.
- SOC_DIS_RESUME, default 8'd10, discharge re-enable threshold in %.
- DEBOUNCE_CYC, default 4, number of consecutive stable cycles required for a request change.
- DEADTIME_CYC, default 8, number of cycles with both enables low after leaving CHARGE or DISCHARGE.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- charger_present  in  1  raw charger-detect request.
- load_request  in  1  raw load/drive request.
- soc_percent  in  8  state of charge from the SOC estimator, 0-100.
- fault_in  in  1  aggregated OV/UV/OT fault, level.
- fault_clear  in  1  single-cycle fault acknowledge.
- charge_en_fsm  out  1  charge path enable, sent to the SOC estimator and contactor.
- discharge_en_fsm  out  1  discharge path enable.
- state_code  out  3  current state.
- fault_latched  out  1  high while in FAULT.
- chg_full  out  1  charge inhibit flag.
- dis_empty  out  1  discharge inhibit flag.

Function
REQ-003 States and codes SHALL be: IDLE=0, CHARGE=1, DISCHARGE=2, DEADTIME=3, FAULT=4; codes 5-7 SHALL recover to FAULT on the next edge.
REQ-004 All outputs SHALL be registered and updated on the same clk edge as the state register; charge_en_fsm=1 only in CHARGE, discharge_en_fsm=1 only in DISCHARGE; both enables SHALL never be 1 in the same cycle.
REQ-005 charger_present and load_request SHALL each be debounced independently: the debounced value flips on the edge at which the raw value has differed from it for DEBOUNCE_CYC consecutive samples; any reversion resets the count to 0.
REQ-006 soc_percent values above 100 SHALL be treated as 100; all comparisons SHALL be unsigned 8-bit.
REQ-007 chg_full SHALL set when soc_percent>=SOC_CHG_STOP and clear when soc_percent<=SOC_CHG_RESUME; between the two thresholds it SHALL hold its value.
REQ-008 dis_empty SHALL set when soc_percent<=SOC_DIS_CUTOFF and clear when soc_percent>=SOC_DIS_RESUME; between the two thresholds it SHALL hold its value.
REQ-009 IDLE transitions, in priority order:
- fault_in=1 -> FAULT.
- debounced charger_present=1 and chg_full=0 -> CHARGE.
- debounced load_request=1 and dis_empty=0 -> DISCHARGE.
- otherwise remain in IDLE.
- Charge wins when both requests are valid.
REQ-010 CHARGE SHALL exit to DEADTIME when the debounced charger_present is 0 or chg_full is set on that edge; DISCHARGE SHALL exit to DEADTIME when the debounced load_request is 0 or dis_empty is set.
REQ-011 DEADTIME SHALL last exactly DEADTIME_CYC cycles using a counter loaded on entry, then go to IDLE; requests arriving during DEADTIME SHALL be serviced only from IDLE.
REQ-012 fault_in=1, sampled on any edge in any state, SHALL move the FSM to FAULT on that edge and drop both enables in the same edge, bypassing DEADTIME.
REQ-013 FAULT SHALL exit to IDLE only on an edge where fault_clear=1 and fault_in=0; fault_clear while fault_in=1 SHALL be ignored and is not remembered.
REQ-014 After FAULT exit, the FSM SHALL pass through IDLE for at least one cycle before entering CHARGE or DISCHARGE.
REQ-015 Simultaneous fault_in and threshold crossing: fault wins; chg_full and dis_empty SHALL still update per REQ-007 and REQ-008.

Reset
REQ-016 While rst_n=0, asynchronously and independent of clk:
- state=IDLE.
- both enables=0.
- fault_latched=0.
- chg_full=0, dis_empty=0.
- debounced requests=0, debounce counters=0, deadtime counter=0.
REQ-017 Reset asserted mid-CHARGE or mid-DISCHARGE SHALL drop the enables immediately, without waiting for a clock edge; after deassertion the FSM SHALL resume from IDLE and take the first transition no earlier than DEBOUNCE_CYC+1 edges later.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- soc=50, charger_present rises and is held -> charge_en_fsm=1 on edge 5 after the rise (DEBOUNCE_CYC=4 plus 1 state edge).
- In CHARGE, soc ramps 96 -> 100 -> chg_full=1, DEADTIME for 8 cycles, then IDLE; charge re-enters only after soc<=95.
- charger_present glitches high for 3 cycles -> no state change, enables stay 0.
- In DISCHARGE, fault_in=1 for 1 cycle -> next edge FAULT, discharge_en_fsm=0, fault_latched=1; fault_clear with fault_in=1 -> stays in FAULT; fault_clear with fault_in=0 -> IDLE.
- Both requests valid, soc=50 -> CHARGE selected; charger removed -> DEADTIME 8 cycles -> IDLE -> DISCHARGE; the two enables never overlap.
- rst_n pulsed low mid-DISCHARGE between clock edges -> discharge_en_fsm=0 before the next edge; state_code=0.
